// File: rtl/vector_mem_sequencer.sv
// Memory-side master for the vector register file: loads operands A1/A2 from word
// memory, starts the vector ALU, waits for ready, then stores A3/A4 back word by word.
module vector_mem_sequencer #(
    parameter int VEC_WIDTH  = 512,
    parameter int MEM_WIDTH  = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] op_a_addr,
    input  logic [ADDR_WIDTH-1:0] op_b_addr,
    input  logic [ADDR_WIDTH-1:0] res_lo_addr,
    input  logic [ADDR_WIDTH-1:0] res_hi_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_en,
    input  logic [MEM_WIDTH-1:0]  mem_rdata,
    output logic                  mem_wr_en,
    output logic [MEM_WIDTH-1:0]  mem_wdata,
    output logic [VEC_WIDTH-1:0]  rf_data_in,
    output logic                  rf_write_enable,
    output logic                  rf_select_register,
    input  logic [VEC_WIDTH-1:0]  rf_data_out,
    output logic                  alu_start,
    input  logic                  alu_ready,
    output logic [3:0]            dbg_state
);
    localparam int N  = VEC_WIDTH / MEM_WIDTH;
    localparam int CW = $clog2(N + 1);
    localparam int TW = $clog2(TIMEOUT + 2);
    localparam logic [CW-1:0] CNT_LOAD_END = CW'(N);
    localparam logic [CW-1:0] CNT_ST_END   = CW'(N - 1);
    localparam logic [TW-1:0] TMO_LAST     = TW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_A, S_WR_A, S_LOAD_B, S_WR_B, S_RUN, S_WAIT,
        S_SNAP_LO, S_ST_LO, S_SNAP_HI, S_ST_HI, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [VEC_WIDTH-1:0]  buf_q, buf_d;
    logic [ADDR_WIDTH-1:0] a_q, a_d, b_q, b_d, lo_q, lo_d, hi_q, hi_d;
    logic                  error_q, error_d;

    assign busy      = (state_q != S_IDLE);
    assign error     = error_q;
    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tmo_q   <= '0;
            buf_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            buf_q   <= buf_d;
            a_q     <= a_d;
            b_q     <= b_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            error_q <= error_d;
        end
    end

    // Handshakes: start is a level sampled only in IDLE; alu_start is a one-cycle
    // pulse; alu_ready is honoured only in WAIT, where the file latches A3/A4.
    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        tmo_d              = tmo_q;
        buf_d              = buf_q;
        a_d                = a_q;
        b_d                = b_q;
        lo_d               = lo_q;
        hi_d               = hi_q;
        error_d            = error_q;
        done               = 1'b0;
        mem_addr           = '0;
        mem_rd_en          = 1'b0;
        mem_wr_en          = 1'b0;
        mem_wdata          = '0;
        rf_data_in         = '0;
        rf_write_enable    = 1'b0;
        rf_select_register = 1'b0;
        alu_start          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = op_a_addr;
                    b_d     = op_b_addr;
                    lo_d    = res_lo_addr;
                    hi_d    = res_hi_addr;
                    error_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_LOAD_A;
                end
            end
            S_LOAD_A, S_LOAD_B: begin
                // Read word c while capturing word c-1 returned by last cycle's read.
                if (cnt_q != CNT_LOAD_END) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = ((state_q == S_LOAD_A) ? a_q : b_q) + ADDR_WIDTH'(cnt_q);
                end
                for (int k = 0; k < N; k++) begin
                    if (cnt_q == CW'(k + 1)) buf_d[k*MEM_WIDTH +: MEM_WIDTH] = mem_rdata;
                end
                if (cnt_q == CNT_LOAD_END) begin
                    cnt_d   = '0;
                    state_d = (state_q == S_LOAD_A) ? S_WR_A : S_WR_B;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WR_A: begin
                rf_write_enable = 1'b1;
                rf_data_in      = buf_q;
                state_d         = S_LOAD_B;
            end
            S_WR_B: begin
                rf_write_enable    = 1'b1;
                rf_select_register = 1'b1;
                rf_data_in         = buf_q;
                state_d            = S_RUN;
            end
            S_RUN: begin
                alu_start = 1'b1;
                tmo_d     = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (alu_ready) begin
                    state_d = S_SNAP_LO;
                end else if (TIMEOUT != 0 && tmo_q == TMO_LAST) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_SNAP_LO, S_SNAP_HI: begin
                rf_select_register = (state_q == S_SNAP_HI);
                buf_d              = rf_data_out;
                cnt_d              = '0;
                state_d            = (state_q == S_SNAP_HI) ? S_ST_HI : S_ST_LO;
            end
            S_ST_LO, S_ST_HI: begin
                rf_select_register = (state_q == S_ST_HI);
                mem_wr_en          = 1'b1;
                mem_addr           = ((state_q == S_ST_HI) ? hi_q : lo_q) + ADDR_WIDTH'(cnt_q);
                for (int k = 0; k < N; k++) begin
                    if (cnt_q == CW'(k)) mem_wdata = buf_q[k*MEM_WIDTH +: MEM_WIDTH];
                end
                if (cnt_q == CNT_ST_END) begin
                    cnt_d   = '0;
                    state_d = (state_q == S_ST_HI) ? S_DONE : S_SNAP_HI;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Directed bench for vector_mem_sequencer: cycle-table checks of one full transaction,
// plus hand-written sequences for address wrap, ALU timeout, mid-store reset and restart.
module tb_vector_mem_sequencer;
    localparam int VW = 512;
    localparam int MW = 32;
    localparam int AW = 10;
    localparam int N  = VW / MW;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [AW-1:0] op_a_addr, op_b_addr, res_lo_addr, res_hi_addr;
    logic          busy, done, error;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en, mem_wr_en;
    logic [MW-1:0] mem_rdata = '0;
    logic [MW-1:0] mem_wdata;
    logic [VW-1:0] rf_data_in, rf_data_out;
    logic          rf_write_enable, rf_select_register;
    logic          alu_start;
    logic          alu_ready = 1'b0;
    logic [3:0]    dbg_state;

    always #5 clk = ~clk;

    vector_mem_sequencer #(.VEC_WIDTH(VW), .MEM_WIDTH(MW), .ADDR_WIDTH(AW), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .op_a_addr(op_a_addr), .op_b_addr(op_b_addr),
        .res_lo_addr(res_lo_addr), .res_hi_addr(res_hi_addr),
        .busy(busy), .done(done), .error(error),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
        .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
        .rf_data_in(rf_data_in), .rf_write_enable(rf_write_enable),
        .rf_select_register(rf_select_register), .rf_data_out(rf_data_out),
        .alu_start(alu_start), .alu_ready(alu_ready), .dbg_state(dbg_state)
    );

    // Memory model: 1-cycle read latency; writes are logged as {addr, data}.
    logic [MW-1:0]      mem [0:1023];
    logic [AW+MW-1:0]   wlog[$];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
        if (mem_wr_en) wlog.push_back({mem_addr, mem_wdata});
    end

    // Register file model: A1/A2 written through the write port, A3/A4 preset.
    logic [VW-1:0] a1_q = '0, a2_q = '0, a3_v, a4_v;
    always @(posedge clk) begin
        if (rf_write_enable) begin
            if (rf_select_register) a2_q <= rf_data_in;
            else                    a1_q <= rf_data_in;
        end
    end
    assign rf_data_out = rf_select_register ? a4_v : a3_v;

    int checks = 0;
    int errors = 0;
    logic [AW+MW-1:0] exp_q[$];
    bit ready_en = 1'b1;
    bit stray_en = 1'b0;

    logic [6:0]    tr_ctl  [0:255];
    logic [AW-1:0] tr_addr [0:255];
    logic [MW-1:0] tr_wdata[0:255];
    logic          tr_err  [0:255];

    typedef struct {
        int            cyc;
        logic [6:0]    ctl;
        logic [AW-1:0] addr;
        logic [MW-1:0] wdata;
        bit            chk_a;
        bit            chk_d;
    } vec_t;
    vec_t tbl[19];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] mk_vec(input logic [MW-1:0] base);
        logic [VW-1:0] v;
        for (int k = 0; k < N; k++) v[k*MW +: MW] = base + MW'(k);
        return v;
    endfunction

    task automatic push_exp(input logic [AW-1:0] lo, input logic [AW-1:0] hi);
        for (int k = 0; k < N; k++) exp_q.push_back({lo + AW'(k), 32'h1000 + MW'(k)});
        for (int k = 0; k < N; k++) exp_q.push_back({hi + AW'(k), 32'h2000 + MW'(k)});
    endtask

    task automatic check_writes(input int base_idx, input string tag);
        int n = exp_q.size();
        check({tag, "_wcount"}, 64'(wlog.size() - base_idx), 64'(n));
        for (int i = 0; i < n && base_idx + i < wlog.size(); i++)
            check({tag, "_wr"}, 64'(wlog[base_idx + i]), 64'(exp_q[i]));
        exp_q.delete();
    endtask

    task automatic record(input int c);
        tr_ctl[c]   = {busy, done, mem_rd_en, mem_wr_en, rf_write_enable, rf_select_register, alu_start};
        tr_addr[c]  = mem_addr;
        tr_wdata[c] = mem_wdata;
        tr_err[c]   = error;
    endtask

    // Called at a negedge; cycle 0 is the cycle in which start is first high.
    task automatic run_txn(input logic [AW-1:0] a, input logic [AW-1:0] b,
                           input logic [AW-1:0] lo, input logic [AW-1:0] hi,
                           input bit hold_start, input int rst_at, output int done_cyc);
        op_a_addr = a; op_b_addr = b; res_lo_addr = lo; res_hi_addr = hi;
        start = 1'b1;
        done_cyc = -1;
        record(0);
        for (int c = 1; c < 200; c++) begin
            @(negedge clk);
            start = hold_start;
            rst   = (c == rst_at);
            record(c);
            if (done) begin
                done_cyc = c;
                break;
            end
            if (rst_at >= 0 && c == rst_at + 4) break;
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int w = 0;
        while (done !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check(name, 64'(done), 64'(1));
        @(negedge clk);
    endtask

    // ALU responder: ready pulse 5 cycles after alu_start; optional stray ready outside WAIT.
    initial begin
        int cd = 0;
        bit fire;
        forever begin
            @(negedge clk);
            fire = 1'b0;
            if (rst) cd = 0;
            else if (ready_en && alu_start) cd = 5;
            else if (cd > 0) begin
                cd--;
                fire = (cd == 0);
            end
            alu_ready = fire || (stray_en && rf_write_enable);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end expected end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dc;
        int w0;
        logic [AW-1:0] wa;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int k = 0; k < N; k++) begin
            mem[k]         = MW'(k + 1);
            mem[256 + k]   = 32'hA0 + MW'(k);
        end
        a3_v = mk_vec(32'h1000);
        a4_v = mk_vec(32'h2000);
        op_a_addr = '0; op_b_addr = '0; res_lo_addr = '0; res_hi_addr = '0;

        tbl[0]  = '{0,  7'b0000000, 10'h000, 32'h0, 0, 0};
        tbl[1]  = '{1,  7'b1010000, 10'h000, 32'h0, 1, 0};
        tbl[2]  = '{16, 7'b1010000, 10'h00F, 32'h0, 1, 0};
        tbl[3]  = '{17, 7'b1000000, 10'h000, 32'h0, 0, 0};
        tbl[4]  = '{18, 7'b1000100, 10'h000, 32'h0, 0, 0};
        tbl[5]  = '{19, 7'b1010000, 10'h100, 32'h0, 1, 0};
        tbl[6]  = '{34, 7'b1010000, 10'h10F, 32'h0, 1, 0};
        tbl[7]  = '{35, 7'b1000000, 10'h000, 32'h0, 0, 0};
        tbl[8]  = '{36, 7'b1000110, 10'h000, 32'h0, 0, 0};
        tbl[9]  = '{37, 7'b1000001, 10'h000, 32'h0, 0, 0};
        tbl[10] = '{38, 7'b1000000, 10'h000, 32'h0, 0, 0};
        tbl[11] = '{42, 7'b1000000, 10'h000, 32'h0, 0, 0};
        tbl[12] = '{43, 7'b1000000, 10'h000, 32'h0, 0, 0};
        tbl[13] = '{44, 7'b1001000, 10'h200, 32'h1000, 1, 1};
        tbl[14] = '{59, 7'b1001000, 10'h20F, 32'h100F, 1, 1};
        tbl[15] = '{60, 7'b1000010, 10'h000, 32'h0, 0, 0};
        tbl[16] = '{61, 7'b1001010, 10'h300, 32'h2000, 1, 1};
        tbl[17] = '{76, 7'b1001010, 10'h30F, 32'h200F, 1, 1};
        tbl[18] = '{77, 7'b1100000, 10'h000, 32'h0, 0, 0};

        // Reset with start held high: everything quiet, then first start accepted.
        rst = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ctl", 64'({busy, done, error, mem_rd_en, mem_wr_en, rf_write_enable,
                             rf_select_register, alu_start}), 64'(0));
        check("rst_addr", 64'(mem_addr), 64'(0));
        check("rst_wdata", 64'(mem_wdata), 64'(0));
        check_vec("rst_rf_data_in", rf_data_in, '0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_first_start_busy", 64'(busy), 64'(1));
        start = 1'b0;
        wait_done("rst_first_done");

        // Main transaction, cycle table.
        w0 = wlog.size();
        push_exp(10'h200, 10'h300);
        run_txn(10'h000, 10'h100, 10'h200, 10'h300, 1'b0, -1, dc);
        check("main_done_cycle", 64'(dc), 64'(77));
        for (int i = 0; i < 19; i++) begin
            check($sformatf("tbl_ctl_c%0d", tbl[i].cyc), 64'(tr_ctl[tbl[i].cyc]), 64'(tbl[i].ctl));
            if (tbl[i].chk_a)
                check($sformatf("tbl_addr_c%0d", tbl[i].cyc), 64'(tr_addr[tbl[i].cyc]), 64'(tbl[i].addr));
            if (tbl[i].chk_d)
                check($sformatf("tbl_wdata_c%0d", tbl[i].cyc), 64'(tr_wdata[tbl[i].cyc]), 64'(tbl[i].wdata));
        end
        check("main_error", 64'(tr_err[77]), 64'(0));
        check_vec("main_a1", a1_q, mk_vec(32'h1));
        check_vec("main_a2", a2_q, mk_vec(32'hA0));
        check_writes(w0, "main");

        // Start during DONE is ignored; start in the following IDLE is accepted.
        start = 1'b1;
        @(negedge clk);
        check("done_start_ignored", 64'(busy), 64'(0));
        @(negedge clk);
        check("idle_start_accepted", 64'(busy), 64'(1));
        start = 1'b0;
        wait_done("restart_done");

        // Operand A wraps past the top of the address space.
        for (int k = 0; k < N; k++) begin
            wa = 10'h3F8 + AW'(k);
            mem[wa] = 32'h5000 + MW'(k);
        end
        run_txn(10'h3F8, 10'h100, 10'h200, 10'h300, 1'b0, -1, dc);
        check("wrap_done_cycle", 64'(dc), 64'(77));
        check("wrap_addr_c1", 64'(tr_addr[1]), 64'(10'h3F8));
        check("wrap_addr_c8", 64'(tr_addr[8]), 64'(10'h3FF));
        check("wrap_addr_c9", 64'(tr_addr[9]), 64'(10'h000));
        check("wrap_addr_c16", 64'(tr_addr[16]), 64'(10'h007));
        check_vec("wrap_a1", a1_q, mk_vec(32'h5000));
        @(negedge clk);

        // ALU never ready (stray ready outside WAIT only), start held while busy.
        ready_en = 1'b0;
        stray_en = 1'b1;
        w0 = wlog.size();
        run_txn(10'h000, 10'h100, 10'h200, 10'h300, 1'b1, -1, dc);
        check("tmo_done_cycle", 64'(dc), 64'(46));
        check("tmo_error_at_done", 64'(tr_err[46]), 64'(1));
        check("tmo_no_writes", 64'(wlog.size() - w0), 64'(0));
        @(negedge clk);
        check("tmo_error_sticky", 64'({busy, error}), 64'(2'b01));
        ready_en = 1'b1;
        stray_en = 1'b0;
        w0 = wlog.size();
        push_exp(10'h040, 10'h080);
        run_txn(10'h000, 10'h100, 10'h040, 10'h080, 1'b0, -1, dc);
        check("tmo_error_cleared", 64'(tr_err[1]), 64'(0));
        check("tmo_next_done_cycle", 64'(dc), 64'(77));
        check_writes(w0, "after_tmo");
        @(negedge clk);

        // Reset during ST_LO word 5 aborts at once; a new start then completes.
        w0 = wlog.size();
        run_txn(10'h000, 10'h100, 10'h200, 10'h300, 1'b0, 49, dc);
        check("abort_no_done", 64'(dc), 64'(-1));
        check("abort_ctl_c50", 64'(tr_ctl[50]), 64'(0));
        check("abort_ctl_c53", 64'(tr_ctl[53]), 64'(0));
        check("abort_wcount", 64'(wlog.size() - w0), 64'(6));
        w0 = wlog.size();
        push_exp(10'h200, 10'h300);
        run_txn(10'h000, 10'h100, 10'h200, 10'h300, 1'b0, -1, dc);
        check("abort_next_done_cycle", 64'(dc), 64'(77));
        check("abort_next_error", 64'(tr_err[77]), 64'(0));
        check_writes(w0, "after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
